multicycle_control: RTL and testbench

Multi-cycle main control FSM for the 16-bit CPU. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath mux selects, write strobes and the 2-bit `ALUOp` consumed by the ALU control decoder. It stalls on memory through a ready handshake and holds the execute state for a fixed number of cycles on `div`.

---
 rtl/cpu_ctrl_pkg.sv | 43 ++++
 rtl/ctrl_wait_counter.sv | 36 +++
 rtl/multicycle_control.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path:
// FSM states, opcodes, ALUOp codes and datapath select codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10
    } state_e;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ANDI  = 3'b001;
    localparam logic [2:0] OP_ORI   = 3'b010;
    localparam logic [2:0] OP_ADDI  = 3'b011;
    localparam logic [2:0] OP_SLTI  = 3'b100;
    localparam logic [2:0] OP_LW    = 3'b101;
    localparam logic [2:0] OP_SW    = 3'b110;
    localparam logic [2:0] OP_BEQ   = 3'b111;

    localparam logic [2:0] FUNCT_DIV = 3'b011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_TWO  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

endpackage

// File: rtl/ctrl_wait_counter.sv
// Loadable 4-bit down-counter that saturates at zero.
// Used to hold the execute state for multi-cycle ALU ops.
module ctrl_wait_counter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Load has priority; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/
// memory/writeback and decodes datapath controls from the state.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [2:0] Opcode,
    input  logic [2:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [3:0] State,
    output logic       InstrDone
);

    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    state_e state_q;
    state_e state_d;
    logic   wait_zero;
    logic   wait_load;
    logic   unused_zero;

    // Zero feeds the datapath's conditional PC write, not the FSM.
    assign unused_zero = Zero;

    assign wait_load = (state_q == S_DECODE) && (state_d == S_REXEC);

    ctrl_wait_counter u_wait (
        .clk_i      (Clock),
        .rst_ni     (Reset_n),
        .load_i     (wait_load),
        .load_val_i ((Funct == FUNCT_DIV) ? DIV_LOAD : 4'd0),
        .dec_i      (state_q == S_REXEC),
        .zero_o     (wait_zero)
    );

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE: state_d = S_REXEC;
                    OP_ANDI, OP_ORI,
                    OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    default: state_d = S_BRANCH;
                endcase
            end
            S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (MemReady) state_d = S_FETCH;
            S_REXEC:  if (wait_zero) state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode from state; reset masks everything but the PC+2 select.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        IorD        = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALUOP_ADD;
        InstrDone   = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_TWO;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: ALUSrcB = SRCB_BOFF;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                MemToReg  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = MemReady;
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_RTYPE;
            end
            S_RWB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUOp     = ALUOP_RTYPE;
                InstrDone = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ITYPE;
            end
            S_IWB: begin
                RegWrite  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ALUOp     = ALUOP_ITYPE;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                InstrDone   = 1'b1;
            end
            default: ;
        endcase
        if (!Reset_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            IorD        = 1'b0;
            MemToReg    = 1'b0;
            RegDst      = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = SRCB_TWO;
            PCSource    = PCSRC_ALU;
            ALUOp       = ALUOP_ADD;
            InstrDone   = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios
// plus random instruction streams against a sequence-level model.
module tb_multicycle_control;

    localparam int DC = 4;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic [2:0] Opcode;
    logic [2:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite;
    logic       IorD, MemToReg, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic [3:0] State;
    logic       InstrDone;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int st;
        bit mr;
    } step_t;

    step_t q[$];

    multicycle_control #(.DIV_CYCLES(DC)) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Opcode      (Opcode),
        .Funct       (Funct),
        .Zero        (Zero),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IRWrite     (IRWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .IorD        (IorD),
        .MemToReg    (MemToReg),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .State       (State),
        .InstrDone   (InstrDone)
    );

    always #5 Clock = ~Clock;

    function automatic logic [16:0] obs_vec();
        return {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite,
                RegWrite, IorD, MemToReg, RegDst, ALUSrcA,
                ALUSrcB, PCSource, ALUOp, InstrDone};
    endfunction

    // Output table written straight from the per-state description.
    function automatic logic [16:0] exp_vec(int st, bit mr, bit rst);
        logic pcw, pcc, irw, mrd, mwr, rw, iord, m2r, rd, sa, dn;
        logic [1:0] sb, ps, ao;
        {pcw, pcc, irw, mrd, mwr, rw, iord, m2r, rd, sa, dn} = '0;
        sb = 2'b00; ps = 2'b00; ao = 2'b00;
        if (rst) begin
            sb = 2'b01;
        end else begin
            case (st)
                0: begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
                1: sb = 2'b11;
                2: begin sa = 1; sb = 2'b10; end
                3: begin mrd = 1; iord = 1; end
                4: begin rw = 1; m2r = 1; dn = 1; end
                5: begin mwr = 1; iord = 1; dn = mr; end
                6: begin sa = 1; ao = 2'b10; end
                7: begin rd = 1; rw = 1; sa = 1; ao = 2'b10; dn = 1; end
                8: begin sa = 1; sb = 2'b10; ao = 2'b11; end
                9: begin rw = 1; sa = 1; sb = 2'b10; ao = 2'b11; dn = 1; end
                10: begin sa = 1; ao = 2'b01; pcc = 1; ps = 2'b01; dn = 1; end
                default: ;
            endcase
        end
        return {pcw, pcc, irw, mrd, mwr, rw, iord, m2r, rd, sa, sb, ps, ao, dn};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected state walk for one instruction, with stall counts.
    task automatic build(input logic [2:0] op, input logic [2:0] fn,
                         input int fst, input int mst);
        q.delete();
        for (int i = 0; i < fst; i++) q.push_back('{0, 1'b0});
        q.push_back('{0, 1'b1});
        q.push_back('{1, 1'($urandom)});
        case (op)
            3'd0: begin
                int n = (fn == 3'd3) ? DC : 1;
                for (int i = 0; i < n; i++) q.push_back('{6, 1'($urandom)});
                q.push_back('{7, 1'($urandom)});
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
                q.push_back('{8, 1'($urandom)});
                q.push_back('{9, 1'($urandom)});
            end
            3'd5: begin
                q.push_back('{2, 1'($urandom)});
                for (int i = 0; i < mst; i++) q.push_back('{3, 1'b0});
                q.push_back('{3, 1'b1});
                q.push_back('{4, 1'($urandom)});
            end
            3'd6: begin
                q.push_back('{2, 1'($urandom)});
                for (int i = 0; i < mst; i++) q.push_back('{5, 1'b0});
                q.push_back('{5, 1'b1});
            end
            default: q.push_back('{10, 1'($urandom)});
        endcase
    endtask

    // Called just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input string tag, input logic [2:0] op,
                             input logic [2:0] fn, input int fst,
                             input int mst);
        int dones = 0;
        build(op, fn, fst, mst);
        Opcode = op;
        Funct  = fn;
        foreach (q[i]) begin
            MemReady = q[i].mr;
            Zero     = 1'($urandom);
            #1;
            check({tag, "_state"}, 32'(State), 32'(q[i].st));
            check({tag, "_outs"}, 32'(obs_vec()),
                  32'(exp_vec(q[i].st, q[i].mr, 1'b0)));
            if (InstrDone) dones++;
            @(posedge Clock);
            #1;
        end
        check({tag, "_done_count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        Reset_n  = 1'b0;
        MemReady = 1'b1;
        Opcode   = 3'd0;
        Funct    = 3'd0;
        Zero     = 1'b0;
        repeat (2) @(posedge Clock);
        #2;
        check("reset_state", 32'(State), 32'd0);
        check("reset_outs", 32'(obs_vec()), 32'(exp_vec(0, 1'b1, 1'b1)));
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;

        run_instr("addi", 3'd3, 3'd0, 0, 0);
        run_instr("lw_stall", 3'd5, 3'd0, 0, 2);
        run_instr("div", 3'd0, 3'd3, 0, 0);
        run_instr("add", 3'd0, 3'd0, 0, 0);
        run_instr("beq", 3'd7, 3'd0, 0, 0);
        run_instr("sw_stall", 3'd6, 3'd5, 1, 3);
        run_instr("andi_fstall", 3'd1, 3'd0, 2, 0);

        // Reset in the middle of a div, counter at 2.
        Opcode = 3'd0;
        Funct  = 3'd3;
        MemReady = 1'b1;
        #1;
        check("mid_fetch", 32'(State), 32'd0);
        @(posedge Clock); #1;
        check("mid_decode", 32'(State), 32'd1);
        @(posedge Clock); #1;
        check("mid_rexec3", 32'(State), 32'd6);
        @(posedge Clock); #1;
        check("mid_rexec2", 32'(State), 32'd6);
        Reset_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(State), 32'd0);
        check("mid_rst_regwrite", 32'(RegWrite), 32'd0);
        check("mid_rst_outs", 32'(obs_vec()), 32'(exp_vec(0, 1'b1, 1'b1)));
        @(posedge Clock); #1;
        check("mid_rst_hold", 32'(State), 32'd0);
        Reset_n = 1'b1;
        run_instr("div_after_rst", 3'd0, 3'd3, 0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [2:0] op, fn;
            op = 3'($urandom_range(0, 7));
            fn = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
            run_instr("rand", op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
